// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity encodings, widths and
// configuration legality / parity helpers used by the tx (and future rx) blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned PAR_NONE = 32'd0;
  localparam int unsigned PAR_ODD  = 32'd1;
  localparam int unsigned PAR_EVEN = 32'd2;

  localparam int unsigned MIN_DATA_W = 32'd5;
  localparam int unsigned MAX_DATA_W = 32'd9;
  localparam int unsigned BIT_IDX_W  = 32'd4;

  function automatic bit cfg_legal(input int unsigned data_w,
                                   input int unsigned parity,
                                   input int unsigned stop_bits);
    return (data_w >= MIN_DATA_W) && (data_w <= MAX_DATA_W) &&
           (parity <= PAR_EVEN) && (stop_bits >= 32'd1) && (stop_bits <= 32'd2);
  endfunction

  // Words narrower than MAX_DATA_W are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input int unsigned parity);
    logic p;
    p = ^data;
    if (parity == PAR_ODD) begin
      return ~p;
    end else if (parity == PAR_EVEN) begin
      return p;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..D with D captured on start, flags the last
// cycle of each bit and wraps so every bit lasts exactly D+1 cycles.
module uart_baud_cnt #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;

  assign bit_end = run && (cnt_r == div_r);

  // Divisor capture and cycle counter; the counter never exceeds div_r so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= '0;
      cnt_r <= '0;
    end else if (start) begin
      div_r <= div;
      cnt_r <= '0;
    end else if (run) begin
      if (bit_end) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first,
// optional parity, 1 or 2 stop bits, run-time baud divisor captured per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              tx_done
);

  if (!cfg_legal(DATA_W, PARITY, STOP_BITS)) begin : g_cfg_illegal
    $error("uart_tx_cfg: illegal DATA_W/PARITY/STOP_BITS combination");
  end

  tx_state_e             state_r;
  tx_state_e             next_state_s;
  logic [DATA_W-1:0]     shift_r;
  logic                  par_r;
  logic [BIT_IDX_W-1:0]  bit_idx_r;
  logic                  stop_idx_r;
  logic                  tx_bit_r;
  logic                  tx_active_r;
  logic                  tx_done_r;
  logic                  accept_s;
  logic                  bit_end_s;
  logic                  last_data_s;
  logic                  last_stop_s;
  logic                  line_next_s;

  assign in_ready    = (state_r == S_IDLE) && !rst;
  assign accept_s    = in_valid && in_ready;
  assign last_data_s = (bit_idx_r == BIT_IDX_W'(DATA_W - 32'd1));
  assign last_stop_s = (stop_idx_r == 1'(STOP_BITS - 32'd1));

  assign tx_bit    = tx_bit_r;
  assign tx_active = tx_active_r;
  assign tx_done   = tx_done_r;

  uart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_s),
    .run     (state_r != S_IDLE),
    .div     (baud_div),
    .bit_end (bit_end_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state, plus the line level that the next state will drive.
  always_comb begin
    next_state_s = state_r;
    line_next_s  = 1'b1;
    case (state_r)
      S_IDLE: begin
        if (accept_s) next_state_s = S_START;
        else          next_state_s = S_IDLE;
      end
      S_START: begin
        if (bit_end_s) next_state_s = S_DATA;
        else           next_state_s = S_START;
      end
      S_DATA: begin
        if (bit_end_s && last_data_s) begin
          if (PARITY != PAR_NONE) next_state_s = S_PARITY;
          else                    next_state_s = S_STOP;
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) next_state_s = S_STOP;
        else           next_state_s = S_PARITY;
      end
      S_STOP: begin
        if (bit_end_s && last_stop_s) next_state_s = S_IDLE;
        else                          next_state_s = S_STOP;
      end
      default: next_state_s = S_IDLE;
    endcase

    // Moving to the next data bit means the shifter has not yet advanced: look one ahead.
    case (next_state_s)
      S_START: line_next_s = 1'b0;
      S_DATA: begin
        if ((state_r == S_DATA) && bit_end_s) line_next_s = shift_r[1];
        else                                  line_next_s = shift_r[0];
      end
      S_PARITY: line_next_s = par_r;
      default:  line_next_s = 1'b1;
    endcase
  end

  // Captured word, parity bit, data-bit index and stop-bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= '0;
      par_r      <= 1'b0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
    end else if (accept_s) begin
      shift_r    <= in_data;
      par_r      <= parity_bit(MAX_DATA_W'(in_data), PARITY);
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
    end else if (bit_end_s) begin
      case (state_r)
        S_DATA: begin
          shift_r <= shift_r >> 1;
          if (last_data_s) bit_idx_r <= '0;
          else             bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
        end
        S_STOP: begin
          if (last_stop_s) stop_idx_r <= 1'b0;
          else             stop_idx_r <= stop_idx_r + 1'b1;
        end
        default: begin
          bit_idx_r  <= bit_idx_r;
          stop_idx_r <= stop_idx_r;
        end
      endcase
    end
  end

  // Registered pad outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_bit_r    <= 1'b1;
      tx_active_r <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      tx_bit_r    <= line_next_s;
      tx_active_r <= (next_state_s != S_IDLE);
      tx_done_r   <= (state_r == S_STOP) && (next_state_s == S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: several parameter sets, directed and random frames
// compared cycle by cycle against a bit-list reference model.
module tb_uart_tx_cfg;

  localparam int NDUT = 7;

  function automatic int dw_of(input int s);
    case (s)
      3:       return 7;
      5:       return 5;
      6:       return 9;
      default: return 8;
    endcase
  endfunction

  function automatic int par_of(input int s);
    case (s)
      1:       return 2;
      2:       return 1;
      5:       return 1;
      6:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_of(input int s);
    case (s)
      3:       return 2;
      5:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int divw_of(input int s);
    case (s)
      4:       return 4;
      5:       return 8;
      default: return 16;
    endcase
  endfunction

  logic            clk;
  logic            rst;
  logic [8:0]      din;
  logic [15:0]     bdiv;
  logic [NDUT-1:0] vld;
  logic [NDUT-1:0] rdy;
  logic [NDUT-1:0] txb;
  logic [NDUT-1:0] act;
  logic [NDUT-1:0] dn;

  int tests;
  int failed;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W  = dw_of(g);
    localparam int DW = divw_of(g);
    uart_tx_cfg #(
      .DATA_W    (W),
      .PARITY    (par_of(g)),
      .STOP_BITS (sb_of(g)),
      .DIV_W     (DW)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .baud_div  (bdiv[DW-1:0]),
      .in_data   (din[W-1:0]),
      .in_valid  (vld[g]),
      .in_ready  (rdy[g]),
      .tx_bit    (txb[g]),
      .tx_active (act[g]),
      .tx_done   (dn[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word once the instance is ready; returns at the sample point of frame cycle 0.
  task automatic do_accept(input int sel, input logic [8:0] data, input int d);
    int n;
    n = 0;
    while (!rdy[sel] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready s%0d", sel), 32'(rdy[sel]), 32'd1);
    din      = data;
    bdiv     = 16'(d);
    vld[sel] = 1'b1;
    @(negedge clk);
  endtask

  // Reference frame: list of line levels, each held for d+1 cycles.
  task automatic check_frame(input int sel, input logic [8:0] data, input int d,
                             input bit hold, input logic [8:0] nd, input int nd_div);
    bit         q[$];
    logic [8:0] w;
    int         dw;
    int         len;
    dw = dw_of(sel);
    w  = data & 9'((1 << dw) - 1);
    q.push_back(1'b0);
    for (int i = 0; i < dw; i++) q.push_back(w[i]);
    if (par_of(sel) == 2) q.push_back(($countones(w) % 2) == 1);
    if (par_of(sel) == 1) q.push_back(($countones(w) % 2) == 0);
    for (int i = 0; i < sb_of(sel); i++) q.push_back(1'b1);
    len = q.size() * (d + 1);
    for (int c = 0; c < len; c++) begin
      check($sformatf("frame s%0d w%0h d%0d c%0d {bit,act,done,rdy}", sel, w, d, c),
            32'({txb[sel], act[sel], dn[sel], rdy[sel]}),
            32'({q[c / (d + 1)], 1'b1, 1'b0, 1'b0}));
      if (c == 0) begin
        if (hold) begin
          din  = nd;
          bdiv = 16'(nd_div);
        end else begin
          vld[sel] = 1'b0;
          din      = 9'($urandom);
          bdiv     = 16'($urandom);
        end
      end
      @(negedge clk);
    end
    check($sformatf("done s%0d {bit,act,done,rdy}", sel),
          32'({txb[sel], act[sel], dn[sel], rdy[sel]}), 32'b1011);
    if (!hold) begin
      @(negedge clk);
      check($sformatf("idle s%0d {bit,act,done,rdy}", sel),
            32'({txb[sel], act[sel], dn[sel], rdy[sel]}), 32'b1001);
    end
  endtask

  task automatic send(input int sel, input logic [8:0] data, input int d);
    do_accept(sel, data, d);
    check_frame(sel, data, d, 1'b0, 9'h000, 0);
  endtask

  initial begin
    logic [8:0] w1;
    logic [8:0] w2;
    int         s;
    int         d1;
    int         d2;
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    vld    = '0;
    din    = 9'h000;
    bdiv   = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst tx_bit", 32'(txb), 32'(7'h7f));
    check("rst tx_active", 32'(act), 32'd0);
    check("rst tx_done", 32'(dn), 32'd0);
    check("rst in_ready", 32'(rdy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 32'(rdy), 32'(7'h7f));

    send(0, 9'h055, 3);
    send(1, 9'h007, 1);
    send(2, 9'h007, 1);
    send(3, 9'h07f, 2);

    // Held valid: second word goes in the done cycle, one idle-high cycle between.
    do_accept(0, 9'h0a5, 0);
    check_frame(0, 9'h0a5, 0, 1'b1, 9'h03c, 0);
    do_accept(0, 9'h03c, 0);
    check_frame(0, 9'h03c, 0, 1'b0, 9'h000, 0);

    // Reset during the third data bit.
    do_accept(0, 9'h0c4, 3);
    vld[0] = 1'b0;
    repeat (13) @(negedge clk);
    check("mid bit2", 32'({txb[0], act[0]}), 32'b11);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid-frame {bit,act,done,rdy}", 32'({txb[0], act[0], dn[0], rdy[0]}), 32'b1000);
    @(negedge clk);
    check("rst held in_ready", 32'(rdy), 32'd0);
    rst = 1'b0;
    send(0, 9'h081, 3);

    // Divisor change mid-frame only affects the next frame.
    do_accept(0, 9'h0b2, 3);
    check_frame(0, 9'h0b2, 3, 1'b1, 9'h04d, 9);
    do_accept(0, 9'h04d, 9);
    check_frame(0, 9'h04d, 9, 1'b0, 9'h000, 0);

    send(4, 9'($urandom), 15);

    for (int it = 0; it < 24; it++) begin
      s  = $urandom_range(0, NDUT - 1);
      w1 = 9'($urandom);
      w2 = 9'($urandom);
      d1 = $urandom_range(0, 4);
      d2 = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        do_accept(s, w1, d1);
        check_frame(s, w1, d1, 1'b1, w2, d2);
        do_accept(s, w2, d2);
        check_frame(s, w2, d2, 1'b0, 9'h000, 0);
      end else begin
        send(s, w1, d1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
